rate_divisor_controller: RTL and testbench

Parametrised successor to the playback-speed divisor generator. Converts the speed keys into a saturating clock-divisor value for the audio sample-rate divider. Adds:
- single-step-per-press edge detection with press-and-hold auto-repeat;
- a coarse-step mode;
- clamping to the limits instead of refusing the step;
- status flags and a change strobe.

Sits between the synchronised key inputs and the sample-rate divider.

---
 rtl/rate_divisor_controller.sv | 130 +++++++++++++
 tb/tb_rate_divisor_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_divisor_controller.sv
// Playback-speed divisor controller: converts speed keys into a saturating
// clock-divisor value with edge detection, hold auto-repeat and a coarse-step mode.
module rate_divisor_controller #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEFAULT_DIV   = 1136,
  parameter int unsigned MIN_DIV       = 100,
  parameter int unsigned MAX_DIV       = 11236000,
  parameter int unsigned STEP          = 100,
  parameter int unsigned COARSE_MULT   = 10,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_fast,
  input  logic             key_slow,
  input  logic             key_reset,
  input  logic             key_coarse,
  output logic [WIDTH-1:0] frequency_divisor,
  output logic             at_min,
  output logic             at_max,
  output logic             div_changed
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_RELEASE} state_t;

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

  localparam logic [WIDTH-1:0] DEFAULT_W = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_DIV);

  // One extra bit so that div + step and MIN_DIV + step cannot wrap.
  localparam logic [WIDTH:0] MIN_X       = (WIDTH+1)'(MIN_DIV);
  localparam logic [WIDTH:0] MAX_X       = (WIDTH+1)'(MAX_DIV);
  localparam logic [WIDTH:0] STEP_FINE   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] STEP_COARSE = (WIDTH+1)'(STEP * COARSE_MULT);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             dir_fast, dir_next;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH:0]   div_x, step_size, stepped;
  logic             active, any_key, both_keys;

  always_comb begin
    div_x     = {1'b0, frequency_divisor};
    step_size = key_coarse ? STEP_COARSE : STEP_FINE;
    if (key_fast)
      stepped = (div_x < MIN_X + step_size) ? MIN_X : div_x - step_size;
    else
      stepped = (div_x + step_size > MAX_X) ? MAX_X : div_x + step_size;

    active    = key_fast ^ key_slow;
    any_key   = key_fast | key_slow;
    both_keys = key_fast & key_slow;

    state_next = state;
    count_next = count;
    dir_next   = dir_fast;
    div_next   = frequency_divisor;

    if (key_reset) begin
      div_next   = DEFAULT_W;
      state_next = WAIT_RELEASE;
      count_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (active) begin
            div_next   = stepped[WIDTH-1:0];
            count_next = HOLD_LOAD;
            dir_next   = key_fast;
            state_next = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!any_key) begin
            state_next = IDLE;
            count_next = '0;
          end else if (both_keys) begin
            state_next = WAIT_RELEASE;
            count_next = '0;
          end else if (key_fast != dir_fast) begin
            // Direction reversal behaves like a fresh press.
            div_next   = stepped[WIDTH-1:0];
            count_next = HOLD_LOAD;
            dir_next   = key_fast;
            state_next = HOLD;
          end else if (count == '0) begin
            div_next   = stepped[WIDTH-1:0];
            count_next = REPEAT_LOAD;
            state_next = REPEAT;
          end else begin
            count_next = count - 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!any_key) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      count             <= '0;
      dir_fast          <= 1'b0;
      frequency_divisor <= DEFAULT_W;
      at_min            <= (DEFAULT_W == MIN_W);
      at_max            <= (DEFAULT_W == MAX_W);
      div_changed       <= 1'b0;
    end else begin
      state             <= state_next;
      count             <= count_next;
      dir_fast          <= dir_next;
      frequency_divisor <= div_next;
      at_min            <= (div_next == MIN_W);
      at_max            <= (div_next == MAX_W);
      div_changed       <= (div_next != frequency_divisor);
    end
  end

endmodule

// File: tb/tb_rate_divisor_controller.sv
// Scoreboard bench for rate_divisor_controller: stimulus queues expected
// divisor changes; a monitor pops one entry per div_changed strobe.
module tb_rate_divisor_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_fast = 1'b0, key_slow = 1'b0, key_reset = 1'b0, key_coarse = 1'b0;
  logic [31:0] frequency_divisor;
  logic        at_min, at_max, div_changed;

  rate_divisor_controller #(
    .WIDTH(32), .DEFAULT_DIV(1136), .MIN_DIV(100), .MAX_DIV(2000),
    .STEP(100), .COARSE_MULT(10), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_fast(key_fast), .key_slow(key_slow), .key_reset(key_reset), .key_coarse(key_coarse),
    .frequency_divisor(frequency_divisor), .at_min(at_min), .at_max(at_max),
    .div_changed(div_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned div;
    logic        mn;
    logic        mx;
    int unsigned at_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        got_e;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  // cyc equals the index of the most recent rising edge when sampled at negedge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (div_changed) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got div=%0d at edge %0d, required no change",
                 frequency_divisor, cyc);
      end else begin
        got_e = sb.pop_front();
        if (frequency_divisor != got_e.div || at_min != got_e.mn || at_max != got_e.mx ||
            cyc != got_e.at_edge) begin
          fails++;
          $display("FAIL strobe: got div=%0d min=%0b max=%0b edge=%0d, required div=%0d min=%0b max=%0b edge=%0d",
                   frequency_divisor, at_min, at_max, cyc,
                   got_e.div, got_e.mn, got_e.mx, got_e.at_edge);
        end
      end
    end
  end

  task automatic expect_step(input int unsigned d, input int unsigned offset);
    exp_t e;
    e.div     = d;
    e.mn      = (d == 100);
    e.mx      = (d == 2000);
    e.at_edge = cyc + offset;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state and a single fast pulse
    do_reset();
    check("reset_div", frequency_divisor, 1136);
    check("reset_min", at_min, 0);
    check("reset_max", at_max, 0);
    check("reset_chg", div_changed, 0);
    expect_step(1036, 1);
    key_fast = 1'b1;
    wait_neg(1);
    key_fast = 1'b0;
    check("pulse_chg_hi", div_changed, 1);
    check("pulse_flags", {at_min, at_max}, 0);
    wait_neg(1);
    check("pulse_chg_lo", div_changed, 0);
    wait_neg(12);
    check("pulse_div", frequency_divisor, 1036);

    // Hold key_slow for 20 cycles: steps at k, k+8, k+12, k+16
    do_reset();
    expect_step(1236, 1);
    expect_step(1336, 9);
    expect_step(1436, 13);
    expect_step(1536, 17);
    key_slow = 1'b1;
    wait_neg(20);
    key_slow = 1'b0;
    wait_neg(10);
    check("hold_div", frequency_divisor, 1536);

    // Coarse fast pulses down to the minimum clamp
    do_reset();
    key_coarse = 1'b1;
    for (int unsigned i = 0; i < 11; i++) begin
      if (i == 0) expect_step(136, 1);
      if (i == 1) expect_step(100, 1);
      key_fast = 1'b1;
      wait_neg(1);
      key_fast = 1'b0;
      if (i == 10) check("min_last_chg", div_changed, 0);
      wait_neg(2);
    end
    key_coarse = 1'b0;
    check("min_div", frequency_divisor, 100);
    check("min_flag", at_min, 1);

    // Coarse slow pulse clamps to maximum, a second one is a no-op
    do_reset();
    key_coarse = 1'b1;
    expect_step(2000, 1);
    key_slow = 1'b1;
    wait_neg(1);
    key_slow = 1'b0;
    wait_neg(2);
    check("max_flag", at_max, 1);
    key_slow = 1'b1;
    wait_neg(1);
    key_slow = 1'b0;
    check("max_repeat_chg", div_changed, 0);
    wait_neg(2);
    key_coarse = 1'b0;
    expect_step(1900, 1);
    key_fast = 1'b1;
    wait_neg(1);
    key_fast = 1'b0;
    wait_neg(2);
    check("below_max_div", frequency_divisor, 1900);
    check("below_max_flag", at_max, 0);

    // Both keys together do nothing; a later solo press steps
    do_reset();
    key_fast = 1'b1;
    key_slow = 1'b1;
    wait_neg(10);
    key_fast = 1'b0;
    key_slow = 1'b0;
    wait_neg(2);
    check("both_div", frequency_divisor, 1136);
    expect_step(1236, 1);
    key_slow = 1'b1;
    wait_neg(1);
    key_slow = 1'b0;
    wait_neg(3);

    // key_reset while key_fast is held
    do_reset();
    expect_step(1036, 1);
    key_fast = 1'b1;
    wait_neg(3);
    expect_step(1136, 1);
    key_reset = 1'b1;
    wait_neg(1);
    key_reset = 1'b0;
    wait_neg(15);
    check("kreset_held_div", frequency_divisor, 1136);
    key_fast = 1'b0;
    wait_neg(2);
    expect_step(1036, 1);
    key_fast = 1'b1;
    wait_neg(1);
    key_fast = 1'b0;
    wait_neg(3);
    check("kreset_after_div", frequency_divisor, 1036);

    // Asynchronous reset in the middle of a hold
    do_reset();
    expect_step(1236, 1);
    key_slow = 1'b1;
    wait_neg(5);
    rst_n = 1'b0;
    #1;
    check("async_div", frequency_divisor, 1136);
    check("async_chg", div_changed, 0);
    wait_neg(2);
    expect_step(1236, 1);
    rst_n = 1'b1;
    wait_neg(1);
    key_slow = 1'b0;
    wait_neg(5);
    check("async_after_div", frequency_divisor, 1236);

    wait_neg(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
